// File: rtl/dmem_bytelane.sv
// dmem_bytelane: byte-addressed, word-organised data RAM with RV32I load/store
// sizing. Accepts one request per cycle through a valid/ready handshake and
// returns a registered response one cycle after acceptance. When
// CLEAR_ON_RESET is set, the RAM is zeroed word by word after reset.
//
// Ports:
//   clk         clock; all state updates on the rising edge
//   rst         synchronous, active-high reset
//   req_valid   request present
//   req_ready   block can accept a request this cycle
//   req_we      1 = store, 0 = load
//   req_addr    byte address (ADDR_W bits)
//   req_funct3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_wdata   store data, right-aligned
//   rsp_valid   one-cycle response pulse, one cycle after acceptance
//   rsp_rdata   extended load result; 0 for stores, errors and idle cycles
//   rsp_err     misaligned access or illegal size; qualified by rsp_valid
module dmem_bytelane #(
  parameter int unsigned DEPTH_WORDS    = 256,
  parameter int unsigned ADDR_W         = 10,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] clr_cnt, clr_cnt_next;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] word_idx;
  logic [1:0]       lane;
  logic [31:0]      rd_word;
  logic             accept;
  logic             illegal_size;
  logic             misaligned;
  logic             req_err;
  logic             store_go;
  logic [3:0]       byte_en;
  logic [31:0]      wr_data;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_data;

  assign word_idx = req_addr[ADDR_W-1:2];
  assign lane     = req_addr[1:0];
  assign rd_word  = mem[word_idx];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / ready
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    req_ready    = 1'b0;
    case (state)
      S_CLEAR: begin
        clr_cnt_next = clr_cnt + 1'b1;
        if (clr_cnt == LAST_IDX) begin
          state_next = S_IDLE;
        end
      end
      S_IDLE: begin
        req_ready = 1'b1;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // A request that coincides with reset is neither written nor answered.
  assign accept = req_valid & req_ready & ~rst;

  // ---------------------------------------------------------------------------
  // Request decode: size legality, alignment, lane enables
  // ---------------------------------------------------------------------------
  always_comb begin
    illegal_size = 1'b0;
    misaligned   = 1'b0;
    if (req_we) begin
      // Stores only exist as B/H/W; the unsigned variants and 011 are illegal.
      illegal_size = req_funct3[2] | (req_funct3[1:0] == 2'b11);
    end else begin
      illegal_size = (req_funct3[1:0] == 2'b11) | (req_funct3 == 3'b110);
    end
    if (req_funct3[1:0] == 2'b01) begin
      misaligned = lane[0];
    end else if (req_funct3[1:0] == 2'b10) begin
      misaligned = (lane != 2'b00);
    end
  end

  assign req_err  = illegal_size | misaligned;
  assign store_go = accept & req_we & ~req_err;

  always_comb begin
    byte_en = 4'b0000;
    wr_data = '0;
    case (req_funct3[1:0])
      2'b00: begin
        byte_en = 4'b0001 << lane;
        wr_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wr_data = req_wdata;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // RAM: clear sequencer writes take priority; no request is accepted then.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (store_go) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (byte_en[i]) begin
            mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load extraction and extension
  // ---------------------------------------------------------------------------
  always_comb begin
    byte_sel = 8'h00;
    case (lane)
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
  end

  always_comb begin
    load_data = '0;
    case (req_funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'h000000, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'h0000, half_sel};
      3'b010:  load_data = rd_word;
      default: load_data = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept & req_err;
      rsp_rdata <= (accept & ~req_we & ~req_err) ? load_data : '0;
    end
  end

endmodule

// File: doc/dmem_bytelane.md
Name: dmem_bytelane

Overview:
- Parametrised successor to the 256-word data memory.
- Byte-addressed, word-organised RAM with RV32I load/store sizing: byte/half/word stores use byte-lane enables; loads are sign- or zero-extended.
- Valid/ready request with a registered one-cycle response, misalignment/illegal-size error flag, and optional zero-clear sequencer after reset.
- Sits between the execute/memory stage and the data RAM.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, at least 4.
- ADDR_W, 10, byte-address width; must equal log2(DEPTH_WORDS*4).
- CLEAR_ON_RESET, 1, when 1 the RAM is zeroed word-by-word after reset; when 0 RAM contents are left untouched.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_funct3  in  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response pulse, one cycle after acceptance.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  misaligned or illegal size; qualified by rsp_valid.

Behaviour:
- Reset (rst=1 at an edge):
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, clear counter=0.
  - State becomes CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
- FSM states: CLEAR, IDLE.
  - CLEAR: req_ready=0. Write 32'h0 to word[counter], counter+1 each cycle. After word DEPTH_WORDS-1 is written, go to IDLE. Clearing takes exactly DEPTH_WORDS cycles.
  - IDLE: req_ready=1 every cycle. Fully pipelined: one request per cycle, back-to-back allowed.
  - rst asserted mid-CLEAR restarts the clear from word 0.
  - rst asserted with a response pending drops that response, and no write occurs for a request presented in a reset cycle.
- Acceptance: an edge with req_valid=1 and req_ready=1. Requests presented while req_ready=0 are ignored, with no response.
- Response timing:
  - rsp_valid=1 in the cycle after acceptance, for exactly one cycle.
  - rsp_valid=0 in every other cycle, and rsp_rdata/rsp_err are then 0.
- Word index = req_addr[ADDR_W-1:2]; lane = req_addr[1:0].
- Error conditions (rsp_err=1, rsp_rdata=0, RAM unchanged):
  - half access (001/101) with addr[0]=1;
  - word access (010) with addr[1:0]!=0;
  - loads with funct3 011, 110 or 111;
  - stores with funct3[2]=1.
- Stores (valid only):
  - Lane enables: SB = 1<<lane; SH = 0011 or 1100 by addr[1]; SW = 1111.
  - Write data is replicated to the enabled lanes. Only enabled bytes of the word are written, at the acceptance edge.
  - Response: rsp_err=0, rsp_rdata=0.
- Loads:
  - The addressed word is sampled at the acceptance edge. The selected byte/half is extended (B/H sign, BU/HU zero) into rsp_rdata.
  - Read-after-write: a load accepted the cycle after a store to the same word returns the updated bytes. No bypass is needed, since the store commits at its acceptance edge.
- No out-of-range case exists; the address width exactly covers the RAM.
- Without clear, RAM content after power-up is undefined (X in simulation).

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH_WORDS=256 -> req_ready=0 for 256 cycles then 1; a load of word 0x3FC (LW) returns 32'h0, rsp_err=0.
- SW 0x10 = 32'h8899AABB; then LB 0x10, LBU 0x13, LH 0x12, LHU 0x10 -> 32'hFFFFFFBB, 32'h00000088, 32'hFFFF8899, 32'h0000AABB.
- SB 0x11 = 32'h000000CC after the above, then LW 0x10 -> 32'h8899CCBB. SH 0x12 = 32'h00001234, then LW 0x10 -> 32'h1234CCBB.
- SW 0x21 and LH 0x23 -> rsp_err=1, rsp_rdata=0; a subsequent LW 0x20 shows the prior content unchanged. A load with funct3=111 -> rsp_err=1.
- Back-to-back stream: SW 0x40=1, LW 0x40, SW 0x40=2, LW 0x40 on consecutive cycles -> rsp_valid high for 4 consecutive cycles with load data 1 then 2.
- rst pulsed at clear cycle 100 -> clear restarts; req_ready remains 0 for a further 256 cycles. rst during a pending load -> no rsp_valid pulse.
